// File: rtl/udma_ctrl_dp_pkg.sv
// Shared types and helpers for the uDMA controller data-path blocks:
// element size encoding, TX response FSM states and lane extraction.
package udma_ctrl_dp_pkg;

  typedef enum logic [1:0] {
    DS_BYTE = 2'd0,
    DS_HALF = 2'd1,
    DS_WORD = 2'd2
  } datasize_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } dp_out_state_e;

  function automatic logic [2:0] elem_bytes(input datasize_e ds);
    case (ds)
      DS_BYTE: return 3'd1;
      DS_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Encoding 3 is reserved and behaves like a word transfer.
  function automatic datasize_e decode_datasize(input logic [1:0] raw);
    return (raw == 2'd3) ? DS_WORD : datasize_e'(raw);
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input datasize_e   ds);
    logic [31:0] shifted;
    shifted = rdata >> {off, 3'b000};
    case (ds)
      DS_BYTE: return {24'd0, shifted[7:0]};
      DS_HALF: return {16'd0, shifted[15:0]};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/udma_ctrl_dp_out_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous flush.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module udma_ctrl_dp_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udma_ctrl_dp_out_rsp.sv
// uDMA TX channel data path: turns peripheral element requests into L2 reads
// and returns the lane-extracted read data in order over valid/ready.
module udma_ctrl_dp_out_rsp
  import udma_ctrl_dp_pkg::*;
#(
  parameter int L2_AWIDTH  = 18,
  parameter int TRANS_SIZE = 20,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_start_i,
  input  logic [L2_AWIDTH-1:0]  cfg_addr_i,
  input  logic [TRANS_SIZE-1:0] cfg_size_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  cfg_continuous_i,
  input  logic                  cfg_stop_i,
  output logic                  busy_o,
  output logic                  eot_o,
  input  logic                  tx_req_i,
  output logic                  tx_gnt_o,
  output logic [1:0]            tx_datasize_o,
  output logic [31:0]           tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  l2_req_o,
  output logic [L2_AWIDTH-1:0]  l2_addr_o,
  input  logic                  l2_gnt_i,
  input  logic                  l2_rvalid_i,
  input  logic [31:0]           l2_rdata_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  dp_out_state_e         state;
  dp_out_state_e         state_next;
  logic [L2_AWIDTH-1:0]  cur_addr;
  logic [L2_AWIDTH-1:0]  cfg_addr_q;
  logic [TRANS_SIZE-1:0] remaining;
  logic [TRANS_SIZE-1:0] cfg_size_q;
  datasize_e             ds_q;
  logic                  cont_q;
  logic                  eot_cont_q;
  logic [CW-1:0]         outstanding;

  logic [2:0]            eb;
  logic [CW:0]           in_use;
  logic                  has_credit;
  logic                  last_gnt;
  logic                  start_ok;
  logic                  drain_done;
  logic                  discard;
  logic                  rvalid_take;
  logic                  keep;

  logic [1:0]            off_head;
  logic [CW-1:0]         off_count;
  logic [31:0]           buf_head;
  logic [CW-1:0]         buf_count;

  assign eb          = elem_bytes(ds_q);
  assign in_use      = {1'b0, buf_count} + {1'b0, outstanding};
  assign has_credit  = in_use < (CW+1)'(DEPTH);
  assign tx_gnt_o    = l2_req_o && l2_gnt_i;
  assign last_gnt    = tx_gnt_o && (remaining == TRANS_SIZE'(eb));
  assign start_ok    = cfg_start_i && !cfg_stop_i && (state == IDLE) && (outstanding == '0);
  assign drain_done  = (outstanding == '0) && (buf_count == '0);
  // After an abort the channel is IDLE but reads may still be in flight; their data is dropped.
  assign discard     = (state == IDLE) || cfg_stop_i;
  assign rvalid_take = l2_rvalid_i && (outstanding != '0);
  assign keep        = rvalid_take && !discard && (off_count != '0);

  assign l2_addr_o     = {cur_addr[L2_AWIDTH-1:2], 2'b00};
  assign tx_datasize_o = ds_q;
  assign tx_valid_o    = (buf_count != '0);
  assign tx_data_o     = tx_valid_o ? buf_head : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (cfg_stop_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_next = ACTIVE;
        ACTIVE:  if (last_gnt && !cont_q) state_next = DRAIN;
        DRAIN:   if (drain_done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o   = (state != IDLE) || (outstanding != '0);
    eot_o    = eot_cont_q || ((state == DRAIN) && drain_done && !cfg_stop_i);
    l2_req_o = (state == ACTIVE) && tx_req_i && has_credit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr   <= '0;
      cfg_addr_q <= '0;
      remaining  <= '0;
      cfg_size_q <= '0;
      ds_q       <= DS_BYTE;
      cont_q     <= 1'b0;
      eot_cont_q <= 1'b0;
    end else begin
      eot_cont_q <= last_gnt && cont_q && !cfg_stop_i;
      if (start_ok) begin
        cur_addr   <= cfg_addr_i;
        cfg_addr_q <= cfg_addr_i;
        remaining  <= cfg_size_i;
        cfg_size_q <= cfg_size_i;
        ds_q       <= decode_datasize(cfg_datasize_i);
        cont_q     <= cfg_continuous_i;
      end else if (tx_gnt_o) begin
        if (last_gnt && cont_q) begin
          cur_addr  <= cfg_addr_q;
          remaining <= cfg_size_q;
        end else begin
          cur_addr  <= cur_addr + L2_AWIDTH'(eb);
          remaining <= remaining - TRANS_SIZE'(eb);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({tx_gnt_o, rvalid_take})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  udma_ctrl_dp_out_fifo #(
    .WIDTH (2),
    .DEPTH (DEPTH)
  ) u_offset_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (cfg_stop_i),
    .push      (tx_gnt_o),
    .push_data (cur_addr[1:0]),
    .pop       (keep),
    .head      (off_head),
    .count     (off_count)
  );

  udma_ctrl_dp_out_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (cfg_stop_i),
    .push      (keep),
    .push_data (lane_extract(l2_rdata_i, off_head, ds_q)),
    .pop       (tx_valid_o && tx_ready_i),
    .head      (buf_head),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_udma_ctrl_dp_out_rsp.sv
// Directed bench for the uDMA TX response path: an L2 read model with
// programmable latency feeds the DUT, monitors log grants, data and EOTs.
module tb_udma_ctrl_dp_out_rsp;

  logic        clk;
  logic        reset_n;
  logic        cfg_start_i;
  logic [17:0] cfg_addr_i;
  logic [19:0] cfg_size_i;
  logic [1:0]  cfg_datasize_i;
  logic        cfg_continuous_i;
  logic        cfg_stop_i;
  logic        busy_o;
  logic        eot_o;
  logic        tx_req_i;
  logic        tx_gnt_o;
  logic [1:0]  tx_datasize_o;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        l2_req_o;
  logic [17:0] l2_addr_o;
  logic        l2_gnt_i;
  logic        l2_rvalid_i;
  logic [31:0] l2_rdata_i;

  int          vecCount  = 0;
  int          missCount = 0;
  int          cyc       = 0;
  int          lat       = 1;
  logic        fixedMode = 1'b0;
  logic [31:0] fixedData = 32'hAABBCCDD;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } l2_txn_t;

  l2_txn_t     pend[$];
  logic [31:0] gntAddrs[$];
  int          gntCyc[$];
  logic [31:0] rxData[$];
  int          rxCyc[$];
  int          eotCyc[$];

  udma_ctrl_dp_out_rsp dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_start_i      (cfg_start_i),
    .cfg_addr_i       (cfg_addr_i),
    .cfg_size_i       (cfg_size_i),
    .cfg_datasize_i   (cfg_datasize_i),
    .cfg_continuous_i (cfg_continuous_i),
    .cfg_stop_i       (cfg_stop_i),
    .busy_o           (busy_o),
    .eot_o            (eot_o),
    .tx_req_i         (tx_req_i),
    .tx_gnt_o         (tx_gnt_o),
    .tx_datasize_o    (tx_datasize_o),
    .tx_data_o        (tx_data_o),
    .tx_valid_o       (tx_valid_o),
    .tx_ready_i       (tx_ready_i),
    .l2_req_o         (l2_req_o),
    .l2_addr_o        (l2_addr_o),
    .l2_gnt_i         (l2_gnt_i),
    .l2_rvalid_i      (l2_rvalid_i),
    .l2_rdata_i       (l2_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return 32'hC0DE0000 | {16'd0, a[15:0]};
  endfunction

  // In-order L2 read model: rvalid appears lat cycles after the grant.
  always @(posedge clk) begin
    if (!reset_n) begin
      pend.delete();
      l2_rvalid_i <= 1'b0;
      l2_rdata_i  <= 32'd0;
    end else begin
      if (l2_req_o && l2_gnt_i) begin
        pend.push_back('{due: cyc + lat, addr: 32'(l2_addr_o)});
      end
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        l2_rvalid_i <= 1'b1;
        l2_rdata_i  <= fixedMode ? fixedData : dataOf(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        l2_rvalid_i <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_gnt_o) begin
      gntAddrs.push_back(32'(l2_addr_o));
      gntCyc.push_back(cyc);
    end
    if (tx_valid_o && tx_ready_i) begin
      rxData.push_back(tx_data_o);
      rxCyc.push_back(cyc);
    end
    if (eot_o) begin
      eotCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [17:0] addr, input logic [19:0] size,
                               input logic [1:0] ds, input logic cont);
    @(negedge clk);
    cfg_addr_i       = addr;
    cfg_size_i       = size;
    cfg_datasize_i   = ds;
    cfg_continuous_i = cont;
    cfg_start_i      = 1'b1;
    @(negedge clk);
    cfg_start_i      = 1'b0;
  endtask

  task automatic clearLogs;
    @(negedge clk);
    gntAddrs.delete();
    gntCyc.delete();
    rxData.delete();
    rxCyc.delete();
    eotCyc.delete();
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while (busy_o && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) checkOutput("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic waitGrants(input int num, input int maxCyc);
    int n = 0;
    while (gntAddrs.size() < num && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    if (gntAddrs.size() < num) checkOutput("grant_timeout", 32'(gntAddrs.size()), 32'(num));
  endtask

  task automatic checkWords(input string tag, input logic [31:0] base, input int num);
    checkOutput({tag, "_count"}, 32'(rxData.size()), 32'(num));
    for (int i = 0; i < num; i++) begin
      checkOutput($sformatf("%s_%0d", tag, i), rxData[i], dataOf(base + 32'(4 * i)));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, {26'd0, busy_o, eot_o, tx_gnt_o, tx_valid_o, l2_req_o, 1'b0}, 32'd0);
    checkOutput({tag, "_data"}, tx_data_o, 32'd0);
    checkOutput({tag, "_addr"}, 32'(l2_addr_o), 32'd0);
    checkOutput({tag, "_ds"}, 32'(tx_datasize_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vecCount);
    $fatal(1);
  end

  initial begin
    reset_n          = 1'b0;
    cfg_start_i      = 1'b0;
    cfg_addr_i       = '0;
    cfg_size_i       = '0;
    cfg_datasize_i   = 2'd0;
    cfg_continuous_i = 1'b0;
    cfg_stop_i       = 1'b0;
    tx_req_i         = 1'b0;
    tx_ready_i       = 1'b1;
    l2_gnt_i         = 1'b1;

    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    reset_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("post_rst");

    $display("[TB] word transfer");
    clearLogs();
    lat      = 1;
    tx_req_i = 1'b1;
    applyStimulus(18'h100, 20'd16, 2'd2, 1'b0);
    checkOutput("word_ds", 32'(tx_datasize_o), 32'd2);
    checkOutput("word_busy_on", 32'(busy_o), 32'd1);
    waitIdle(50);
    tx_req_i = 1'b0;
    checkOutput("word_gnts", 32'(gntAddrs.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("word_addr_%0d", i), gntAddrs[i], 32'h100 + 32'(4 * i));
    end
    checkWords("word_data", 32'h100, 4);
    checkOutput("word_eot", 32'(eotCyc.size()), 32'd1);
    checkOutput("word_busy_off", 32'(busy_o), 32'd0);
    checkOutput("word_latency", 32'(rxCyc[0] - gntCyc[0]), 32'd2);
    checkOutput("word_stream", 32'(rxCyc[3] - rxCyc[0]), 32'd3);

    $display("[TB] byte transfer");
    clearLogs();
    fixedMode = 1'b1;
    tx_req_i  = 1'b1;
    applyStimulus(18'h203, 20'd3, 2'd0, 1'b0);
    checkOutput("byte_ds", 32'(tx_datasize_o), 32'd0);
    waitIdle(50);
    tx_req_i = 1'b0;
    checkOutput("byte_addr_0", gntAddrs[0], 32'h200);
    checkOutput("byte_addr_1", gntAddrs[1], 32'h204);
    checkOutput("byte_addr_2", gntAddrs[2], 32'h204);
    checkOutput("byte_count", 32'(rxData.size()), 32'd3);
    checkOutput("byte_data_0", rxData[0], 32'h000000AA);
    checkOutput("byte_data_1", rxData[1], 32'h000000DD);
    checkOutput("byte_data_2", rxData[2], 32'h000000CC);
    checkOutput("byte_eot", 32'(eotCyc.size()), 32'd1);

    $display("[TB] half transfer");
    clearLogs();
    tx_req_i = 1'b1;
    applyStimulus(18'h302, 20'd4, 2'd1, 1'b0);
    waitIdle(50);
    tx_req_i = 1'b0;
    checkOutput("half_gnts", 32'(gntAddrs.size()), 32'd2);
    checkOutput("half_addr_0", gntAddrs[0], 32'h300);
    checkOutput("half_addr_1", gntAddrs[1], 32'h304);
    checkOutput("half_data_0", rxData[0], 32'h0000AABB);
    checkOutput("half_data_1", rxData[1], 32'h0000CCDD);
    fixedMode = 1'b0;

    $display("[TB] backpressure");
    clearLogs();
    lat        = 2;
    tx_ready_i = 1'b0;
    tx_req_i   = 1'b1;
    applyStimulus(18'h400, 20'd32, 2'd2, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("bp_gnts_held", 32'(gntAddrs.size()), 32'd4);
    checkOutput("bp_valid", 32'(tx_valid_o), 32'd1);
    checkOutput("bp_head", tx_data_o, 32'hC0DE0400);
    tx_ready_i = 1'b1;
    waitIdle(100);
    tx_req_i = 1'b0;
    checkOutput("bp_gnts_total", 32'(gntAddrs.size()), 32'd8);
    checkWords("bp_data", 32'h400, 8);
    checkOutput("bp_eot", 32'(eotCyc.size()), 32'd1);

    $display("[TB] continuous mode");
    clearLogs();
    lat      = 1;
    tx_req_i = 1'b1;
    applyStimulus(18'h500, 20'd8, 2'd2, 1'b1);
    waitGrants(6, 50);
    tx_req_i = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("cont_addr_%0d", i), gntAddrs[i], (i % 2 == 1) ? 32'h504 : 32'h500);
    end
    checkOutput("cont_eots", 32'(eotCyc.size()), 32'd3);
    checkOutput("cont_busy", 32'(busy_o), 32'd1);
    checkOutput("cont_rx", 32'(rxData.size()), 32'd6);
    @(negedge clk);
    cfg_stop_i = 1'b1;
    @(negedge clk);
    cfg_stop_i = 1'b0;
    waitIdle(20);
    checkOutput("cont_stop_eots", 32'(eotCyc.size()), 32'd3);
    checkOutput("cont_stop_busy", 32'(busy_o), 32'd0);

    $display("[TB] stop mid-run");
    clearLogs();
    lat      = 3;
    tx_req_i = 1'b1;
    applyStimulus(18'h600, 20'd64, 2'd2, 1'b0);
    waitGrants(2, 20);
    cfg_stop_i = 1'b1;
    tx_req_i   = 1'b0;
    @(negedge clk);
    cfg_stop_i = 1'b0;
    checkOutput("stop_valid", 32'(tx_valid_o), 32'd0);
    checkOutput("stop_busy_drain", 32'(busy_o), 32'd1);
    cfg_start_i = 1'b1;
    @(negedge clk);
    cfg_start_i = 1'b0;
    waitIdle(20);
    checkOutput("stop_gnts", 32'(gntAddrs.size()), 32'd2);
    checkOutput("stop_rx", 32'(rxData.size()), 32'd0);
    checkOutput("stop_eot", 32'(eotCyc.size()), 32'd0);
    checkOutput("stop_valid_late", 32'(tx_valid_o), 32'd0);
    clearLogs();
    lat      = 1;
    tx_req_i = 1'b1;
    applyStimulus(18'h700, 20'd8, 2'd2, 1'b0);
    waitIdle(50);
    tx_req_i = 1'b0;
    checkWords("restart_data", 32'h700, 2);
    checkOutput("restart_eot", 32'(eotCyc.size()), 32'd1);

    $display("[TB] reset mid-operation");
    clearLogs();
    lat        = 3;
    tx_ready_i = 1'b0;
    tx_req_i   = 1'b1;
    applyStimulus(18'h800, 20'd64, 2'd2, 1'b0);
    for (int n = 0; n < 20 && !tx_valid_o; n++) @(negedge clk);
    checkOutput("rst_pre_valid", 32'(tx_valid_o), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clearLogs();
    lat        = 1;
    tx_ready_i = 1'b1;
    applyStimulus(18'h900, 20'd8, 2'd2, 1'b0);
    waitIdle(50);
    tx_req_i = 1'b0;
    checkOutput("post_rst_addr_0", gntAddrs[0], 32'h900);
    checkOutput("post_rst_addr_1", gntAddrs[1], 32'h904);
    checkWords("post_rst_data", 32'h900, 2);
    checkOutput("post_rst_eot", 32'(eotCyc.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
